// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// SEG_SCAN_BLINK_EN adds a per-digit blink flag to each bank slot.
package seg_scan_pkg;
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_BLANK_CYCLES = 2;
  localparam int DEF_BLINK_DIV    = 32;

  // Width that holds every value 0..max(a,b)
  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  typedef struct packed {
    logic [1:0] code;
`ifdef SEG_SCAN_BLINK_EN
    logic       blink;
`endif
  } slot_t;
endpackage

// File: rtl/seg_scan_timer.sv
// Restartable cycle counter: done pulses on the cycle the count reaches
// 'last' while enabled, and the count restarts from zero on that same edge.
module seg_scan_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         done
);
  logic [W-1:0] cnt;

  assign done = en && (cnt == last);

  always_ff @(posedge clock) begin
    if (reset || done) cnt <= '0;
    else if (en)       cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS display codes into one shared decoder.
// Optional blink support is compiled in with SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BLINK_DIV    = DEF_BLINK_DIV
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [1:0]                    wr_code,
  input  logic                          wr_blink,
  output logic [1:0]                    code_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_tick
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int SW = cnt_w(PRESCALE, BLANK_CYCLES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);

  slot_t [NUM_DIGITS-1:0] bank;
  state_t                 state, state_nxt;
  logic [AW-1:0]          idx, idx_nxt;   // next digit to be shown
  logic [1:0]             code_nxt;
  logic [NUM_DIGITS-1:0]  en_nxt;
  logic                   tick_nxt;
  logic                   slot_done;
  logic [SW-1:0]          slot_last;

  always_ff @(posedge clock) begin
    if (reset) bank <= '0;
    else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_DIGITS))) begin
      bank[wr_addr].code <= wr_code;
`ifdef SEG_SCAN_BLINK_EN
      bank[wr_addr].blink <= wr_blink;
`endif
    end
  end

  assign slot_last = (state == ST_SHOW) ? SW'(PRESCALE - 1) : SW'(BLANK_CYCLES - 1);

  seg_scan_timer #(.W(SW)) u_slot (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .last  (slot_last),
    .done  (slot_done)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic phase, frame_end, blk_done;

  // A frame ends when the last digit's SHOW expires; idx has already wrapped to 0
  assign frame_end = (state == ST_SHOW) && slot_done && (idx == '0);

  seg_scan_timer #(.W(BW)) u_blink (
    .clock (clock),
    .reset (reset),
    .en    (frame_end),
    .last  (BW'(BLINK_DIV - 1)),
    .done  (blk_done)
  );

  always_ff @(posedge clock) begin
    if (reset)         phase <= 1'b0;
    else if (blk_done) phase <= ~phase;
  end
`else
  logic unused_blink;
  assign unused_blink = wr_blink;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    code_nxt  = code_out;
    en_nxt    = digit_en;
    tick_nxt  = 1'b0;
    if (slot_done) begin
      case (state)
        ST_BLANK: begin
          state_nxt = ST_SHOW;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + AW'(1);
          code_nxt  = bank[idx].code;
          en_nxt    = NUM_DIGITS'(1) << idx;
          tick_nxt  = (idx == '0);
`ifdef SEG_SCAN_BLINK_EN
          if (phase && bank[idx].blink) en_nxt = '0;
`endif
        end
        default: begin
          state_nxt = ST_BLANK;
          en_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_BLANK;
      idx        <= '0;
      code_out   <= 2'b00;
      digit_en   <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      code_out   <= code_nxt;
      digit_en   <= en_nxt;
      frame_tick <= tick_nxt;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a slot-arithmetic reference model
// predicts every cycle's outputs for a 4-digit and a 3-digit instance.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int P  = 4;
  localparam int B  = 2;
  localparam int BD = 2;
  localparam int S  = P + B;

  logic       clock, reset;
  logic       wr_en, wr_blink, wr_en3, wr_blink3;
  logic [1:0] wr_addr, wr_code, wr_addr3, wr_code3;
  logic [1:0] code_out, code_out3;
  logic [N-1:0]  digit_en;
  logic [N3-1:0] digit_en3;
  logic       frame_tick, frame_tick3;

  seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .BLINK_DIV(BD)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .wr_blink(wr_blink), .code_out(code_out), .digit_en(digit_en), .frame_tick(frame_tick));

  seg_scan_ctrl #(.NUM_DIGITS(N3), .PRESCALE(P), .BLANK_CYCLES(B), .BLINK_DIV(BD)) dut3 (
    .clock(clock), .reset(reset), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_code(wr_code3),
    .wr_blink(wr_blink3), .code_out(code_out3), .digit_en(digit_en3), .frame_tick(frame_tick3));

  typedef struct {
    logic [1:0]    code;
    logic [N-1:0]  en;
    logic          tick;
    logic [1:0]    code3;
    logic [N3-1:0] en3;
    logic          tick3;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  bit   stim_done = 0;

  // Reference model state
  int         t;
  bit         armed = 0, prst = 0;
  logic [1:0] mcode [N];
  bit         mblink[N];
  logic [1:0] lat;
  bit         latb;
  bit         pw;
  int         pa;
  logic [1:0] pc;
  bit         pb;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // One clock cycle: predict outputs for the new cycle, then drive its inputs
  task automatic step(input bit rst, input bit we, input logic [1:0] a,
                      input logic [1:0] c, input bit b);
    int   p, k, r, d, f, d3;
    exp_t e;
    @(posedge clock);
    #1;
    if (prst) begin
      t = 1; lat = 0; latb = 0; pw = 0; armed = 1;
      for (int i = 0; i < N; i++) begin mcode[i] = 0; mblink[i] = 0; end
    end else if (armed) t++;
    if (armed) begin
      p = t - 1; k = p / S; r = p % S; d = k % N; f = k / N; d3 = k % N3;
      if (r == B) begin lat = mcode[d]; latb = mblink[d]; end
      if (pw) begin mcode[pa] = pc; mblink[pa] = pb; end
      e.code = lat;
      e.en   = (r >= B) ? N'(1 << d) : '0;
`ifdef SEG_SCAN_BLINK_EN
      if ((r >= B) && latb && ((f / BD) % 2 == 1)) e.en = '0;
`endif
      e.tick  = (r == B) && (d == 0);
      e.code3 = 2'b00;
      e.en3   = (r >= B) ? N3'(1 << d3) : '0;
      e.tick3 = (r == B) && (d3 == 0);
      q.push_back(e);
    end
    reset = rst; wr_en = we; wr_addr = a; wr_code = c; wr_blink = b;
    wr_en3 = we; wr_addr3 = 2'd3; wr_code3 = c; wr_blink3 = b;
    prst = rst; pw = we; pa = int'(a); pc = c; pb = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'(i), 2'(i + 1), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("code_out",    8'(code_out),    8'(e.code));
        chk("digit_en",    8'(digit_en),    8'(e.en));
        chk("frame_tick",  8'(frame_tick),  8'(e.tick));
        chk("code_out3",   8'(code_out3),   8'(e.code3));
        chk("digit_en3",   8'(digit_en3),   8'(e.en3));
        chk("frame_tick3", 8'(frame_tick3), 8'(e.tick3));
      end
    end
  end

  initial begin : stim
    reset = 1; wr_en = 0; wr_addr = 0; wr_code = 0; wr_blink = 0;
    wr_en3 = 0; wr_addr3 = 3; wr_code3 = 0; wr_blink3 = 0;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    // Idle scan after reset: two full frames plus a bit
    idle(54);
    // Load codes, overwrite digit 0 mid-show, collide a write with digit 1's latch
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd1, 2'd1, 0);
    step(0, 1, 2'd2, 2'd2, 0);
    step(0, 1, 2'd3, 2'd3, 0);
    step(0, 1, 2'd0, 2'd3, 0);
    idle(3);
    step(0, 1, 2'd1, 2'd0, 0);
    idle(44);
    // Disabled writes must not touch the bank
    for (int i = 0; i < 30; i++) step(0, 0, 2'd3, 2'($urandom_range(0, 3)), 1);
    // One-cycle reset at cycle 10 of a fresh scan
    step(1, 0, 0, 0, 0);
    idle(9);
    step(1, 0, 0, 0, 0);
    idle(20);
    // Blink flag on digit 1 across five frames
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd1, 2'd2, 1);
    idle(125);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 1));
    idle(2);
    stim_done = 1;
    @(negedge clock);
    @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
